// File: rtl/spi_rdid_responder_if.sv
// SPI target pins plus the local status outputs of spi_rdid_responder.
// master: the SPI bus master / bench side. slave: the responder.
interface spi_rdid_responder_if;
    logic       SPICLK;
    logic       SPIMOSI;
    logic       chip_select;
    logic       SPIMISO;
    logic       cmd_valid;
    logic [7:0] cmd_byte;
    logic       busy;
    logic [7:0] rdid_count;

    modport master (
        output SPICLK, SPIMOSI, chip_select,
        input  SPIMISO, cmd_valid, cmd_byte, busy, rdid_count
    );

    modport slave (
        input  SPICLK, SPIMOSI, chip_select,
        output SPIMISO, cmd_valid, cmd_byte, busy, rdid_count
    );
endinterface

// File: rtl/spi_rdid_responder.sv
// SPI mode-0 target answering JEDEC RDID (0x9F) with a 3-byte ID.
// All SPI inputs are oversampled in the clk domain.
// Optional macro SPI_RDID_MISO_TRISTATE_EN: SPIMISO floats (1'bz) outside RESP
// so several targets can share MISO; otherwise it is driven 0.
module spi_rdid_responder #(
    parameter logic [7:0]  RDID_CMD    = 8'h9F,
    parameter logic [7:0]  MFG_ID      = 8'h20,
    parameter logic [7:0]  MEM_TYPE    = 8'h20,
    parameter logic [7:0]  MEM_CAP     = 8'h15,
    parameter int unsigned SYNC_STAGES = 2      // must be >= 2
) (
    input  logic                 clk,
    input  logic                 reset,
    spi_rdid_responder_if.slave  bus
);
    localparam int unsigned RESP_BITS = 24;
    localparam int unsigned CNT_W     = 5;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CMD    = 2'd1,
        RESP   = 2'd2,
        IGNORE = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0] sclk_ff;
    logic [SYNC_STAGES-1:0] mosi_ff;
    logic [SYNC_STAGES-1:0] cs_ff;
    logic                   sclk_hist;
    logic                   cs_hist;

    logic sclk_s;
    logic mosi_s;
    logic cs_s;
    logic sclk_rise;
    logic sclk_fall;
    logic cs_fall;

    state_t                 state;
    logic [6:0]             cmd_sr;
    logic [RESP_BITS-1:0]   resp_sr;
    logic [CNT_W-1:0]       bit_cnt;
    logic                   miso_q;
    logic                   cmd_valid_q;
    logic [7:0]             cmd_byte_q;
    logic                   busy_q;
    logic [7:0]             rdid_count_q;
    logic [7:0]             cmd_next_c;

    // Input synchronizers followed by one history flop for edge detection
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sclk_ff   <= '0;
            mosi_ff   <= '0;
            cs_ff     <= '0;
            sclk_hist <= 1'b0;
            cs_hist   <= 1'b0;
        end else begin
            sclk_ff   <= {sclk_ff[SYNC_STAGES-2:0], bus.SPICLK};
            mosi_ff   <= {mosi_ff[SYNC_STAGES-2:0], bus.SPIMOSI};
            cs_ff     <= {cs_ff[SYNC_STAGES-2:0], bus.chip_select};
            sclk_hist <= sclk_ff[SYNC_STAGES-1];
            cs_hist   <= cs_ff[SYNC_STAGES-1];
        end
    end

    assign sclk_s     = sclk_ff[SYNC_STAGES-1];
    assign mosi_s     = mosi_ff[SYNC_STAGES-1];
    assign cs_s       = cs_ff[SYNC_STAGES-1];
    assign sclk_rise  = sclk_s & ~sclk_hist;
    assign sclk_fall  = ~sclk_s & sclk_hist;
    assign cs_fall    = ~cs_s & cs_hist;
    assign cmd_next_c = {cmd_sr, mosi_s};

    // Transaction FSM: command capture, ID shift-out, deselect handling
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            cmd_sr       <= '0;
            resp_sr      <= '0;
            bit_cnt      <= '0;
            miso_q       <= 1'b0;
            cmd_valid_q  <= 1'b0;
            cmd_byte_q   <= '0;
            busy_q       <= 1'b0;
            rdid_count_q <= '0;
        end else begin
            cmd_valid_q <= 1'b0;
            if (cs_s) begin
                // Deselect beats any SPICLK edge seen in the same cycle
                state   <= IDLE;
                bit_cnt <= '0;
                miso_q  <= 1'b0;
                busy_q  <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (cs_fall) begin
                            bit_cnt <= '0;
                            busy_q  <= 1'b1;
                            state   <= CMD;
                        end
                    end
                    CMD: begin
                        if (sclk_rise) begin
                            cmd_sr  <= cmd_next_c[6:0];
                            bit_cnt <= bit_cnt + CNT_W'(1);
                            if (bit_cnt == CNT_W'(7)) begin
                                cmd_byte_q  <= cmd_next_c;
                                cmd_valid_q <= 1'b1;
                                if (cmd_next_c == RDID_CMD) begin
                                    resp_sr      <= {MFG_ID, MEM_TYPE, MEM_CAP};
                                    bit_cnt      <= '0;
                                    rdid_count_q <= rdid_count_q + 8'd1;
                                    state        <= RESP;
                                end else begin
                                    busy_q <= 1'b0;
                                    state  <= IGNORE;
                                end
                            end
                        end
                    end
                    RESP: begin
                        // Shift out on falls; zero fill gives 0 after the 24 ID bits
                        if (sclk_fall) begin
                            miso_q  <= resp_sr[RESP_BITS-1];
                            resp_sr <= {resp_sr[RESP_BITS-2:0], 1'b0};
                            if (bit_cnt != CNT_W'(RESP_BITS)) begin
                                bit_cnt <= bit_cnt + CNT_W'(1);
                            end
                        end
                    end
                    IGNORE: begin
                        miso_q <= 1'b0;
                        busy_q <= 1'b0;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.cmd_valid  = cmd_valid_q;
    assign bus.cmd_byte   = cmd_byte_q;
    assign bus.busy       = busy_q;
    assign bus.rdid_count = rdid_count_q;

    // MISO pin: miso_q only ever holds data while in RESP
`ifdef SPI_RDID_MISO_TRISTATE_EN
    assign bus.SPIMISO = (state == RESP) ? miso_q : 1'bz;
`else
    assign bus.SPIMISO = miso_q;
`endif

endmodule

// File: doc/spi_rdid_responder.md
Name: spi_rdid_responder

Overview:
- Synthesizable SPI target (mode 0, MSB first) that answers the JEDEC Read-Identification command (0x9F) with a 3-byte ID.
- Serves as a stand-in for the serial flash on the SPI bus, so spi_master can be exercised on hardware and in benches without the vendor flash model.
- Runs entirely in the system clock domain. It oversamples SPICLK, SPIMOSI and chip_select through synchronizers.
- Reports every received command byte to local logic.

Parameters:
- RDID_CMD, 8'h9F: opcode that triggers the ID response.
- MFG_ID, 8'h20: first response byte (manufacturer ID).
- MEM_TYPE, 8'h20: second response byte (memory type).
- MEM_CAP, 8'h15: third response byte (memory capacity).
- SYNC_STAGES, 2: flop stages on each SPI input, minimum 2.

Ports:
- clk  input  1  system clock; all logic is rising-edge.
- reset  input  1  asynchronous, active-high reset.
- SPICLK  input  1  SPI serial clock from the master, idle low.
- SPIMOSI  input  1  master-out data, sampled on SPICLK rising.
- chip_select  input  1  active-low select.
- SPIMISO  output  1  target-out data, updated on SPICLK falling.
- cmd_valid  output  1  one-clk pulse when the 8th command bit is captured.
- cmd_byte  output  8  last command byte; held until the next cmd_valid.
- busy  output  1  high while selected and in CMD or RESP.
- rdid_count  output  8  count of RDID commands accepted; wraps 255->0.

Behaviour:
- Reset values: SPIMISO=0, cmd_valid=0, cmd_byte=0, busy=0, rdid_count=0, state=IDLE. Reset clears all shift registers, the bit counter, synchronizers and edge-detect registers.
- Input path: SYNC_STAGES synchronizer flops, then one history flop. A rise/fall is detected when (sync, history) = (1,0) or (0,1).
  - Detection latency: SYNC_STAGES+1 clk after the pin edge.
- Timing constraint: SPICLK high and low phases must each be at least 2*(SYNC_STAGES+1) clk. Faster bus clocks are unsupported and unchecked.
- Deselect: chip_select synchronized high forces IDLE in the next clk, from any state. It clears the bit counter, sets SPIMISO=0 and busy=0. cmd_valid is not generated for a partial byte.
- States:
  - IDLE: waiting for select. On the select falling edge, clear bit_cnt and go to CMD.
  - CMD: on each SPICLK rise, shift SPIMOSI into cmd_sr (MSB first) and increment bit_cnt.
    - On the 8th rise: cmd_byte <= captured byte and cmd_valid=1 for one clk.
    - If the byte == RDID_CMD: load resp_sr = {MFG_ID, MEM_TYPE, MEM_CAP}, set bit_cnt=0, increment rdid_count, go to RESP.
    - Otherwise go to IGNORE.
  - RESP: on each SPICLK fall, SPIMISO <= resp_sr[23], resp_sr shifts left with zero fill, bit_cnt increments.
    - After 24 bits are driven, further falls drive 0.
    - SPIMOSI is ignored. SPICLK rises do nothing.
  - IGNORE: SPIMISO=0 and busy=0 until deselect.
- SPIMISO update latency: at most SYNC_STAGES+2 clk after the SPICLK falling pin edge. It is stable before the next rising edge under the timing constraint above.
- Simultaneous events: a deselect detected in the same clk as an SPICLK edge wins, and the edge is discarded.
- Reset mid-transaction: outputs return to reset values immediately. A new transaction requires a fresh select falling edge; a select already held low at reset release does not start CMD.

Optional Feature:
- Macro SPI_RDID_MISO_TRISTATE_EN.
- Defined: SPIMISO is driven 1'bz whenever not in RESP (IDLE, CMD, IGNORE, reset, deselect), so several targets can share MISO.
- Undefined: SPIMISO is driven 0 in those cases. All other behaviour is identical.

Test Plan:
- Reset held 5 clk, then released -> SPIMISO=0 (or z with the macro), cmd_valid=0, cmd_byte=0x00, rdid_count=0, busy=0.
- Select low, clock 0x9F then 32 SPICLK cycles at half-period 8 clk -> one cmd_valid with cmd_byte=0x9F, rdid_count=1.
  - Master samples SPIMISO bits = 0x20, 0x20, 0x15 then 0x00.
- Select low, send 0x05, clock 24 more cycles -> cmd_valid with cmd_byte=0x05, SPIMISO stays 0, rdid_count unchanged, busy low after the command byte.
- Deselect after 12 response bits, reselect, send 0x9F -> response restarts at bit 7 of 0x20, rdid_count increments by 1.
- Deselect after 5 command bits -> no cmd_valid, state IDLE. The next full 0x9F is decoded correctly with no leftover bits.
- Assert reset during RESP bit 10 -> SPIMISO=0 and busy=0 within 1 clk. Without a new select falling edge, subsequent SPICLK toggles produce no cmd_valid.
